// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Router 1x3 packet source. It buffers one payload, sends the
//            header, payload and parity under router_busy back-pressure, and
//            reports router_err per packet.
// Options  : ROUTER_TX_PARITY_INJECT_EN enables parity corruption on inject_err.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
    parameter int IPG_CYCLES = 3,
    parameter int MAX_LEN    = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_ready,
    input  logic       pay_valid,
    input  logic [7:0] pay_data,
    output logic       pay_ready,
    input  logic       router_busy,
    input  logic       router_err,
    input  logic       inject_err,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       bad_req,
    output logic       tx_done,
    output logic       pkt_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_PAR  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam logic [3:0] C_IPG = 4'(IPG_CYCLES);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [5:0] r_len;
    logic [5:0] r_idx;
    logic [5:0] w_idx_next;
    logic [7:0] r_header;
    logic [7:0] r_parity;
    logic [7:0] w_par_out;
    logic [3:0] r_cnt;
    logic       r_err_acc;
    logic [7:0] r_buf [0:MAX_LEN-1];

    logic       w_req_hs;
    logic       w_req_bad;
    logic       w_pay_hs;
    logic       w_last;

    logic       w_req_ready_d;
    logic       w_pay_ready_d;
    logic       w_pkt_valid_d;
    logic [7:0] w_data_d;
    logic       w_bad_req_d;
    logic       w_tx_done_d;
    logic       w_pkt_err_d;

    assign w_req_hs  = req_valid && req_ready;
    assign w_req_bad = (req_addr == 2'd3) || (req_len == 6'd0);
    assign w_pay_hs  = pay_valid && pay_ready;
    assign w_last    = (r_idx == (r_len - 6'd1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_hs && !w_req_bad)    w_state_next = S_LOAD;
            S_LOAD: if (w_pay_hs && w_last)        w_state_next = S_HDR;
            S_HDR:  if (!router_busy)              w_state_next = S_PAY;
            S_PAY:  if (!router_busy && w_last)    w_state_next = S_PAR;
            S_PAR:  if (!router_busy)              w_state_next = S_GAP;
            S_GAP:  if (r_cnt == 4'd1)             w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE: if (w_req_hs)     w_idx_next = 6'd0;
            S_LOAD: if (w_pay_hs)     w_idx_next = w_last ? 6'd0 : (r_idx + 6'd1);
            S_PAY:  if (!router_busy) w_idx_next = r_idx + 6'd1;
            default: ;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        w_req_ready_d = (w_state_next == S_IDLE);
        w_pay_ready_d = (w_state_next == S_LOAD);
        w_pkt_valid_d = (w_state_next == S_HDR) || (w_state_next == S_PAY);
        w_bad_req_d   = w_req_hs && w_req_bad;
        w_tx_done_d   = (r_state == S_GAP) && (r_cnt == 4'd1);
        w_pkt_err_d   = w_tx_done_d && (r_err_acc || router_err);
        case (w_state_next)
            S_HDR:   w_data_d = r_header;
            S_PAY:   w_data_d = r_buf[w_idx_next];
            S_PAR:   w_data_d = w_par_out;
            default: w_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_len     <= 6'd0;
            r_idx     <= 6'd0;
            r_header  <= 8'h00;
            r_parity  <= 8'h00;
            r_cnt     <= 4'd0;
            r_err_acc <= 1'b0;
            req_ready <= 1'b0;
            pay_ready <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            bad_req   <= 1'b0;
            tx_done   <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            r_idx     <= w_idx_next;
            req_ready <= w_req_ready_d;
            pay_ready <= w_pay_ready_d;
            pkt_valid <= w_pkt_valid_d;
            data_out  <= w_data_d;
            bad_req   <= w_bad_req_d;
            tx_done   <= w_tx_done_d;
            pkt_err   <= w_pkt_err_d;
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs && !w_req_bad) begin
                        r_len    <= req_len;
                        r_header <= {req_len, req_addr};
                        r_parity <= {req_len, req_addr};
                    end
                end
                S_LOAD: begin
                    if (w_pay_hs) begin
                        r_parity <= r_parity ^ pay_data;
                    end
                end
                S_PAR: begin
                    if (!router_busy) begin
                        r_cnt     <= C_IPG;
                        r_err_acc <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_cnt     <= r_cnt - 4'd1;
                    r_err_acc <= r_err_acc | router_err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_pay_hs) begin
            r_buf[r_idx] <= pay_data;
        end
    end

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic r_inject;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_inject <= 1'b0;
        end else if ((r_state == S_IDLE) && w_req_hs && !w_req_bad) begin
            r_inject <= inject_err;
        end
    end

    assign w_par_out = r_inject ? ~r_parity : r_parity;
`else
    logic w_unused_inject;

    assign w_unused_inject = inject_err;
    assign w_par_out       = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Purpose  : Scoreboard bench for router_pkt_tx with randomized packets, stalls
//            and back-pressure. Honors ROUTER_TX_PARITY_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int IPG = 3;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [5:0] req_len = 6'd0;
    logic       req_ready;
    logic       pay_valid = 1'b0;
    logic [7:0] pay_data = 8'h00;
    logic       pay_ready;
    logic       router_busy;
    logic       router_err = 1'b0;
    logic       inject_err = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       bad_req;
    logic       tx_done;
    logic       pkt_err;

    logic busy_rand = 1'b0;
    logic busy_dir  = 1'b0;
    bit   rand_busy = 1'b0;
    assign router_busy = busy_rand | busy_dir;

    int vectors = 0;
    int miscompares = 0;

    bit       exp_pv[$];
    bit [7:0] exp_data[$];
    bit       err_q[$];
    bit [7:0] pay_buf[$];

    bit in_pkt = 1'b0;
    int done_at = -1;
    int ncyc = 0;

    router_pkt_tx #(.IPG_CYCLES(IPG), .MAX_LEN(63)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
        .router_busy(router_busy), .router_err(router_err), .inject_err(inject_err),
        .pkt_valid(pkt_valid), .data_out(data_out), .bad_req(bad_req),
        .tx_done(tx_done), .pkt_err(pkt_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Random back-pressure, updated just after each active edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            busy_rand = rand_busy && ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: samples shortly before each posedge, when inputs for that edge are stable.
    initial begin
        bit       epv;
        bit [7:0] ed;
        bit       eerr;
        forever begin
            @(negedge clock);
            #3;
            ncyc++;
            if (!resetn) begin
                exp_pv.delete();
                exp_data.delete();
                err_q.delete();
                in_pkt  = 1'b0;
                done_at = -1;
                continue;
            end
            if (done_at >= 0 && ncyc == done_at) begin
                done_at = -1;
                chk("tx_done_time", 32'(tx_done), 32'd1);
                if (err_q.size() == 0) begin
                    tmo("pkt_err_queue");
                end else begin
                    eerr = err_q.pop_front();
                    chk("pkt_err", 32'(pkt_err), 32'(eerr));
                end
            end else begin
                chk("done_quiet", 32'({tx_done, pkt_err}), 32'd0);
            end
            if (pkt_valid) in_pkt = 1'b1;
            if (in_pkt && !router_busy) begin
                if (exp_pv.size() == 0) begin
                    chk("unexpected_byte", 32'({pkt_valid, data_out}), 32'h1ff);
                    in_pkt = 1'b0;
                end else begin
                    epv = exp_pv.pop_front();
                    ed  = exp_data.pop_front();
                    chk("router_byte", 32'({pkt_valid, data_out}), 32'({epv, ed}));
                    if (!epv) begin
                        in_pkt  = 1'b0;
                        done_at = ncyc + IPG + 1;
                    end
                end
            end else if (!in_pkt) begin
                chk("idle_data", 32'({pkt_valid, data_out}), 32'd0);
            end
        end
    end

    task automatic do_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
        int n = 0;
        req_valid  = 1'b1;
        req_addr   = a;
        req_len    = l;
        inject_err = inj;
        while (!req_ready && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!req_ready) tmo("req_wait");
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        inject_err = 1'b0;
    endtask

    // Reference: header {len,addr}, payload, then XOR of everything (inverted on injection).
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                            input int mode, input bit eerr);
        bit [7:0] p;
        int n;
        p = {l, a};
        exp_pv.push_back(1'b1);
        exp_data.push_back(p);
        for (int i = 0; i < int'(l); i++) begin
            exp_pv.push_back(1'b1);
            exp_data.push_back(pay_buf[i]);
            p = p ^ pay_buf[i];
        end
        if (inj && INJ_ON) p = ~p;
        exp_pv.push_back(1'b0);
        exp_data.push_back(p);
        err_q.push_back(eerr);
        do_req(a, l, inj);
        for (int i = 0; i < int'(l); i++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                pay_valid = 1'b0;
                pay_data  = 8'($urandom);
                @(posedge clock);
                #1;
            end
            pay_valid = 1'b1;
            pay_data  = pay_buf[i];
            n = 0;
            while (!pay_ready && n < 200) begin
                @(posedge clock);
                #1;
                n++;
            end
            if (!pay_ready) tmo("pay_wait");
            chk("load_quiet", 32'(pkt_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        pay_valid = 1'b0;
    endtask

    task automatic bad_request(input logic [1:0] a, input logic [5:0] l);
        do_req(a, l, 1'b0);
        chk("bad_req_pulse", 32'(bad_req), 32'd1);
        chk("bad_req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        chk("bad_req_clear", 32'({bad_req, pkt_valid}), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_pv.size() != 0 || err_q.size() != 0) && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_pv.size() != 0 || err_q.size() != 0) tmo(name);
    endtask

    task automatic fill_rand(input int l);
        pay_buf.delete();
        for (int i = 0; i < l; i++) pay_buf.push_back(8'($urandom));
    endtask

    initial begin
        int n;
        int l;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 32'({req_ready, pay_ready, pkt_valid, data_out, bad_req, tx_done, pkt_err}), 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        pay_buf = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b0, 0, 1'b0);
        wait_drain("basic");

        // Hold the 0x22 byte with two busy cycles.
        send_pkt(2'd1, 6'd3, 1'b0, 0, 1'b0);
        n = 0;
        while (!(pkt_valid && data_out == 8'h22) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!(pkt_valid && data_out == 8'h22)) tmo("bp_find");
        busy_dir = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_hold1", 32'(data_out), 32'h22);
        @(posedge clock);
        #1;
        chk("bp_hold2", 32'(data_out), 32'h22);
        busy_dir = 1'b0;
        @(posedge clock);
        #1;
        chk("bp_next", 32'(data_out), 32'h33);
        wait_drain("backpressure");

        bad_request(2'd3, 6'd5);
        bad_request(2'd0, 6'd0);

        fill_rand(63);
        send_pkt(2'd0, 6'd63, 1'b0, 1, 1'b0);
        wait_drain("maxlen");

        // router_err in the second gap cycle.
        fill_rand(4);
        send_pkt(2'd2, 6'd4, 1'b0, 0, 1'b1);
        n = 0;
        while (pkt_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        router_err = 1'b1;
        @(posedge clock);
        #1;
        router_err = 1'b0;
        wait_drain("err_pkt");
        fill_rand(5);
        send_pkt(2'd1, 6'd5, 1'b0, 0, 1'b0);
        wait_drain("clean_pkt");

        pay_buf = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b1, 0, 1'b0);
        wait_drain("inject");

        // Reset while a payload byte is being presented.
        fill_rand(8);
        send_pkt(2'd2, 6'd8, 1'b0, 0, 1'b0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("in_pay", 32'(pkt_valid), 32'd1);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_abort", 32'({pkt_valid, data_out}), 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_abort", 32'(req_ready), 32'd1);

        rand_busy = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) bad_request(2'd3, 6'($urandom_range(0, 63)));
                else                           bad_request(2'($urandom_range(0, 2)), 6'd0);
            end else begin
                l = ($urandom_range(0, 4) == 0) ? 63 : int'($urandom_range(1, 16));
                fill_rand(l);
                send_pkt(2'($urandom_range(0, 2)), 6'(l), 1'($urandom_range(0, 1)), 2, 1'b0);
            end
        end
        rand_busy = 1'b0;
        wait_drain("final");
        repeat (IPG + 3) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
